// File: rtl/aer_event_scheduler.sv
// aer_event_scheduler: round-robin arbitration of event producers onto the AER link,
// buffered in a FIFO and issued one REQ/ACK cycle at a time.
`default_nettype none

module aer_event_scheduler #(
    parameter int NUM_SRC         = 4,
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int ADDR_W          = IMAGE_SIZE_BITS + 1,
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          ENABLE,
    input  logic                          FLUSH,
    input  logic [NUM_SRC-1:0]            SRC_VALID,
    input  logic [NUM_SRC*ADDR_W-1:0]     SRC_ADDR,
    output logic [NUM_SRC-1:0]            SRC_READY,
    input  logic                          AERIN_CTRL_BUSY,
    output logic                          FOUND_NEXT_INDEX,
    output logic [ADDR_W-1:0]             NEXT_INDEX,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [CNT_W-1:0]              EVT_COUNT,
    output logic                          SCHED_IDLE
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W = FA_W + 1;
    localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(FIFO_DEPTH);
    localparam logic [1:0]       C_RETRY = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_cand;
    logic                  w_gnt_any;
    logic                  w_arb_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_restrobe;
    logic [1:0]            r_wait_cnt;
    logic [1:0]            w_wait_cnt_nxt;
    logic [ADDR_W-1:0]     w_src_addr [NUM_SRC];
    logic [ADDR_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FA_W-1:0]       r_wr_ptr;
    logic [FA_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_strobe;
    logic [ADDR_W-1:0]     r_next_index;
    logic [CNT_W-1:0]      r_evt_count;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_src_addr[gi] = SRC_ADDR[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Full is judged on the registered level, so a same-cycle pop never admits a push.
    assign w_arb_ok = ENABLE & ~FLUSH & (r_level < C_DEPTH);

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = PTR_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_gnt_any && SRC_VALID[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        if (!w_arb_ok) begin
            w_gnt_any = 1'b0;
        end
    end

    assign SRC_READY = w_gnt_any ? (NUM_SRC'(1) << w_gnt_idx) : '0;
    assign w_push    = w_gnt_any;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_src_addr[w_gnt_idx];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FA_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FA_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // A pop is withheld during FLUSH so the flushed head is never issued.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pop          = 1'b0;
        w_restrobe     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ENABLE && !FLUSH && (r_level != '0) && !AERIN_CTRL_BUSY) begin
                    w_pop          = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (AERIN_CTRL_BUSY) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_wait_cnt == C_RETRY) begin
                    w_restrobe     = 1'b1;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!AERIN_CTRL_BUSY) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_strobe     <= 1'b0;
            r_next_index <= '0;
            r_evt_count  <= '0;
        end else begin
            r_strobe <= w_pop | w_restrobe;
            if (w_pop) begin
                r_next_index <= r_mem[r_rd_ptr];
                r_evt_count  <= r_evt_count + CNT_W'(1);
            end
        end
    end

    assign FOUND_NEXT_INDEX = r_strobe;
    assign NEXT_INDEX       = r_next_index;
    assign FIFO_LEVEL       = r_level;
    assign EVT_COUNT        = r_evt_count;
    assign SCHED_IDLE       = (r_level == '0) && (r_state == S_IDLE) && !AERIN_CTRL_BUSY;

endmodule

`default_nettype wire

// File: tb/tb_aer_event_scheduler.sv
// tb_aer_event_scheduler: scenario tasks with an address scoreboard for aer_event_scheduler.
`default_nettype none

module tb_aer_event_scheduler;

    localparam int AW = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          FLUSH;
    logic [3:0]    SRC_VALID;
    logic [4*AW-1:0] SRC_ADDR;
    logic [3:0]    SRC_READY;
    logic          AERIN_CTRL_BUSY;
    logic          FOUND_NEXT_INDEX;
    logic [AW-1:0] NEXT_INDEX;
    logic [3:0]    FIFO_LEVEL;
    logic [15:0]   EVT_COUNT;
    logic          SCHED_IDLE;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] e;
    int pend;
    int busy_left;

    aer_event_scheduler dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FLUSH(FLUSH),
        .SRC_VALID(SRC_VALID), .SRC_ADDR(SRC_ADDR), .SRC_READY(SRC_READY),
        .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY), .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
        .NEXT_INDEX(NEXT_INDEX), .FIFO_LEVEL(FIFO_LEVEL), .EVT_COUNT(EVT_COUNT),
        .SCHED_IDLE(SCHED_IDLE)
    );

    always #5 CLK = ~CLK;

    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; ENABLE = 1'b1; FLUSH = 1'b0; SRC_VALID = '0; SRC_ADDR = '0;
        AERIN_CTRL_BUSY = 1'b0; pend = 0; busy_left = 0;
        exp_q.delete();
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    // Link-controller model: BUSY for two cycles, starting the cycle after a strobe.
    task automatic aer_respond();
        if (pend != 0) begin
            busy_left = 2;
            pend = 0;
        end
        AERIN_CTRL_BUSY = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    endtask

    task automatic test_reset();
        do_reset();
        next_cycle();
        #1;
        n_cmp++; if (SRC_READY !== 4'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0000", SRC_READY); end
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0) begin n_bad++; $display("FAIL rst_strobe got %b want 0", FOUND_NEXT_INDEX); end
        n_cmp++; if (NEXT_INDEX !== 9'd0) begin n_bad++; $display("FAIL rst_index got %h want 0", NEXT_INDEX); end
        n_cmp++; if (FIFO_LEVEL !== 4'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", FIFO_LEVEL); end
        n_cmp++; if (EVT_COUNT !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", EVT_COUNT); end
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL rst_idle got %b want 1", SCHED_IDLE); end
    endtask

    task automatic test_single();
        do_reset();
        next_cycle();
        SRC_VALID = 4'b0010; SRC_ADDR[1*AW +: AW] = 9'h005;
        #1;
        n_cmp++; if (SRC_READY !== 4'b0010) begin n_bad++; $display("FAIL single_ready got %b want 0010", SRC_READY); end
        exp_q.push_back(9'h005);
        next_cycle();
        SRC_VALID = 4'b0000;
        #1;
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0) begin n_bad++; $display("FAIL single_early_strobe got %b want 0", FOUND_NEXT_INDEX); end
        next_cycle();
        #1;
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL single_strobe got %b want 1", FOUND_NEXT_INDEX); end
        e = exp_q.pop_front();
        n_cmp++; if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL single_index got %h want %h", NEXT_INDEX, e); end
        n_cmp++; if (EVT_COUNT !== 16'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", EVT_COUNT); end
        next_cycle(); AERIN_CTRL_BUSY = 1'b1;
        next_cycle(); AERIN_CTRL_BUSY = 1'b0;
        next_cycle();
        #1;
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL single_idle got %b want 1", SCHED_IDLE); end
    endtask

    task automatic test_round_robin();
        int seq [4];
        int exp_next;
        int exp_cnt;
        do_reset();
        exp_next = 0;
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            next_cycle();
            aer_respond();
            SRC_VALID = (cyc < 30) ? 4'hF : 4'h0;
            for (int i = 0; i < 4; i++) SRC_ADDR[i*AW +: AW] = AW'(i*64 + seq[i]);
            #1;
            if (SRC_READY !== 4'b0) begin
                n_cmp++;
                if (SRC_READY !== (4'b0001 << exp_next)) begin
                    n_bad++; $display("FAIL rr_grant got %b want %b", SRC_READY, 4'b0001 << exp_next);
                end
                exp_q.push_back(AW'(exp_next*64 + seq[exp_next]));
                seq[exp_next]++;
                exp_next = (exp_next + 1) % 4;
            end
            if (FOUND_NEXT_INDEX === 1'b1) begin
                pend = 1;
                exp_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rr_order got %h want no strobe", NEXT_INDEX);
                end else begin
                    e = exp_q.pop_front();
                    if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL rr_order got %h want %h", NEXT_INDEX, e); end
                end
                n_cmp++; if (EVT_COUNT !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rr_count got %0d want %0d", EVT_COUNT, exp_cnt); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr_drain got %0d left want 0", exp_q.size()); end
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL rr_idle got %b want 1", SCHED_IDLE); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        AERIN_CTRL_BUSY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            SRC_VALID = 4'b0001; SRC_ADDR[0 +: AW] = AW'(9'h100 + k);
            #1;
            n_cmp++; if (SRC_READY !== 4'b0001) begin n_bad++; $display("FAIL full_fill_ready got %b want 0001", SRC_READY); end
            exp_q.push_back(AW'(9'h100 + k));
        end
        next_cycle();
        SRC_ADDR[0 +: AW] = 9'h108;
        #1;
        n_cmp++; if (FIFO_LEVEL !== 4'd8) begin n_bad++; $display("FAIL full_level got %0d want 8", FIFO_LEVEL); end
        n_cmp++; if (SRC_READY !== 4'b0) begin n_bad++; $display("FAIL full_ready got %b want 0000", SRC_READY); end
        next_cycle();
        AERIN_CTRL_BUSY = 1'b0;
        #1;
        n_cmp++; if (SRC_READY !== 4'b0) begin n_bad++; $display("FAIL full_pop_cycle_ready got %b want 0000", SRC_READY); end
        next_cycle();
        #1;
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL full_strobe got %b want 1", FOUND_NEXT_INDEX); end
        e = exp_q.pop_front();
        n_cmp++; if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL full_index got %h want %h", NEXT_INDEX, e); end
        n_cmp++; if (FIFO_LEVEL !== 4'd7) begin n_bad++; $display("FAIL full_level_after got %0d want 7", FIFO_LEVEL); end
        n_cmp++; if (SRC_READY !== 4'b0001) begin n_bad++; $display("FAIL full_resume got %b want 0001", SRC_READY); end
        exp_q.push_back(9'h108);
        pend = 1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            next_cycle();
            aer_respond();
            SRC_VALID = 4'b0000;
            #1;
            if (FOUND_NEXT_INDEX === 1'b1) begin
                pend = 1;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL full_order got %h want no strobe", NEXT_INDEX);
                end else begin
                    e = exp_q.pop_front();
                    if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL full_order got %h want %h", NEXT_INDEX, e); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL full_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_restrobe();
        do_reset();
        next_cycle();
        SRC_VALID = 4'b0100; SRC_ADDR[2*AW +: AW] = 9'h033;
        #1;
        n_cmp++; if (SRC_READY !== 4'b0100) begin n_bad++; $display("FAIL retry_ready got %b want 0100", SRC_READY); end
        exp_q.push_back(9'h033);
        next_cycle();
        SRC_VALID = 4'b0000;
        next_cycle();
        #1;
        e = exp_q.pop_front();
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL retry_first_strobe got %b want 1", FOUND_NEXT_INDEX); end
        n_cmp++; if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL retry_first_index got %h want %h", NEXT_INDEX, e); end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #1;
            n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0) begin n_bad++; $display("FAIL retry_gap_strobe got %b want 0 at gap %0d", FOUND_NEXT_INDEX, k); end
        end
        next_cycle();
        #1;
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL retry_strobe got %b want 1", FOUND_NEXT_INDEX); end
        n_cmp++; if (NEXT_INDEX !== e) begin n_bad++; $display("FAIL retry_index got %h want %h", NEXT_INDEX, e); end
        n_cmp++; if (EVT_COUNT !== 16'd1) begin n_bad++; $display("FAIL retry_count got %0d want 1", EVT_COUNT); end
        next_cycle(); AERIN_CTRL_BUSY = 1'b1;
        next_cycle(); AERIN_CTRL_BUSY = 1'b0;
        next_cycle();
        #1;
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL retry_idle got %b want 1", SCHED_IDLE); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            SRC_VALID = 4'b0001; SRC_ADDR[0 +: AW] = AW'(9'h040 + k);
            if (k >= 3) AERIN_CTRL_BUSY = 1'b1;
            #1;
            n_cmp++; if (SRC_READY !== 4'b0001) begin n_bad++; $display("FAIL flush_fill_ready got %b want 0001", SRC_READY); end
            exp_q.push_back(AW'(9'h040 + k));
            if (k == 2) begin
                e = exp_q.pop_front();
                n_cmp++; if (NEXT_INDEX !== e || FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL flush_issue got %h/%b want %h/1", NEXT_INDEX, FOUND_NEXT_INDEX, e); end
            end
        end
        next_cycle();
        FLUSH = 1'b1; SRC_ADDR[0 +: AW] = 9'h046;
        #1;
        n_cmp++; if (FIFO_LEVEL !== 4'd5) begin n_bad++; $display("FAIL flush_level_before got %0d want 5", FIFO_LEVEL); end
        n_cmp++; if (SRC_READY !== 4'b0) begin n_bad++; $display("FAIL flush_refuse got %b want 0000", SRC_READY); end
        next_cycle();
        FLUSH = 1'b0; SRC_VALID = 4'b0000;
        #1;
        n_cmp++; if (FIFO_LEVEL !== 4'd0) begin n_bad++; $display("FAIL flush_level got %0d want 0", FIFO_LEVEL); end
        exp_q.delete();
        next_cycle();
        AERIN_CTRL_BUSY = 1'b0;
        #1;
        n_cmp++; if (SCHED_IDLE !== 1'b0) begin n_bad++; $display("FAIL flush_inflight_idle got %b want 0", SCHED_IDLE); end
        next_cycle();
        #1;
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL flush_idle got %b want 1", SCHED_IDLE); end
        n_cmp++; if (EVT_COUNT !== 16'd1) begin n_bad++; $display("FAIL flush_count got %0d want 1", EVT_COUNT); end
        next_cycle();
        #1;
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0) begin n_bad++; $display("FAIL flush_no_strobe got %b want 0", FOUND_NEXT_INDEX); end
    endtask

    task automatic test_reset_midevent();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            SRC_VALID = 4'b0001; SRC_ADDR[0 +: AW] = AW'(9'h080 + k);
            if (k >= 3) AERIN_CTRL_BUSY = 1'b1;
            #1;
            exp_q.push_back(AW'(9'h080 + k));
            if (k == 2) begin
                e = exp_q.pop_front();
                n_cmp++; if (NEXT_INDEX !== e || FOUND_NEXT_INDEX !== 1'b1) begin n_bad++; $display("FAIL rstmid_issue got %h/%b want %h/1", NEXT_INDEX, FOUND_NEXT_INDEX, e); end
            end
        end
        next_cycle();
        SRC_VALID = 4'b0000;
        #1;
        n_cmp++; if (FIFO_LEVEL !== 4'd3) begin n_bad++; $display("FAIL rstmid_level_before got %0d want 3", FIFO_LEVEL); end
        RST = 1'b1; AERIN_CTRL_BUSY = 1'b0;
        #1;
        n_cmp++; if (FIFO_LEVEL !== 4'd0) begin n_bad++; $display("FAIL rstmid_level got %0d want 0", FIFO_LEVEL); end
        n_cmp++; if (NEXT_INDEX !== 9'd0) begin n_bad++; $display("FAIL rstmid_index got %h want 0", NEXT_INDEX); end
        n_cmp++; if (EVT_COUNT !== 16'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", EVT_COUNT); end
        n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0) begin n_bad++; $display("FAIL rstmid_strobe got %b want 0", FOUND_NEXT_INDEX); end
        n_cmp++; if (SCHED_IDLE !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got %b want 1", SCHED_IDLE); end
        exp_q.delete();
        next_cycle();
        next_cycle();
        RST = 1'b0;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            #1;
            n_cmp++; if (FOUND_NEXT_INDEX !== 1'b0 || FIFO_LEVEL !== 4'd0) begin n_bad++; $display("FAIL rstmid_after got %b/%0d want 0/0", FOUND_NEXT_INDEX, FIFO_LEVEL); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_restrobe();
        test_flush();
        test_reset_midevent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
